// File: rtl/leitor_dump_registradores.sv
// rtl/leitor_dump_registradores.sv - register bank debug dump engine
// Walks every register index, snapshots each word and streams it out over valid/ready.
module leitor_dump_registradores #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] RegLido,
  input  logic [DATA_W-1:0] DadoLido,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpIdx,
  output logic [DATA_W-1:0] DumpData,
  output logic              Busy,
  output logic              Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] didx_q, didx_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    didx_d  = didx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end
      S_READ: begin
        // The bank read is combinational, so the word for idx_q is valid this cycle.
        data_d  = DadoLido;
        didx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (DumpReady) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      didx_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      didx_q  <= didx_d;
      data_q  <= data_d;
    end
  end

  assign RegLido   = idx_q;
  assign DumpValid = valid_q;
  assign DumpIdx   = didx_q;
  assign DumpData  = data_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_leitor_dump_registradores.sv
// tb/tb_leitor_dump_registradores.sv - scoreboard bench for the register dump engine
// Bank model with a registered write port; expected words are queued at each Start.
module tb_leitor_dump_registradores;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] RegLido;
  logic [DATA_W-1:0] DadoLido;
  logic              DumpValid;
  logic              DumpReady = 1'b0;
  logic [ADDR_W-1:0] DumpIdx;
  logic [DATA_W-1:0] DumpData;
  logic              Busy;
  logic              Done;

  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [DATA_W-1:0] model [NUM_REGS];
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  word_t exp_q [$];
  int    compared   = 0;
  int    mismatched = 0;
  int    done_cnt   = 0;
  logic  prev_done  = 1'b0;

  leitor_dump_registradores #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .RegLido(RegLido), .DadoLido(DadoLido),
    .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpIdx(DumpIdx), .DumpData(DumpData),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (wr_en) bank[wr_addr] <= wr_data;
  assign DadoLido = bank[RegLido];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the head of the expected queue.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (DumpValid && DumpReady) begin
        compared++;
        assert (exp_q.size() != 0) else begin
          mismatched++;
          $error("FAIL sb_unexpected observed=idx%0h expected=none", DumpIdx);
        end
        if (exp_q.size() != 0) begin
          word_t e;
          e = exp_q.pop_front();
          chk("sb_idx", 32'(DumpIdx), 32'(e.idx));
          chk("sb_data", 32'(DumpData), 32'(e.data));
        end
      end
      if (Done) begin
        done_cnt++;
        chk("done_width", 32'(prev_done), 0);
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic bank_write(input int a, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    model[a] = d;
    @(posedge Clock) #1;
    wr_en = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back('{ADDR_W'(i), model[i]});
  endtask

  task automatic start_dump();
    Start = 1'b1;
    @(posedge Clock) #1;
    Start = 1'b0;
  endtask

  task automatic wait_word(input int idx);
    int k;
    for (k = 0; k < 100 && !(DumpValid && DumpIdx == ADDR_W'(idx)); k++) @(posedge Clock) #1;
    chk($sformatf("reach_idx%0d", idx), 32'(k < 100), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget && Busy; k++) @(posedge Clock) #1;
    chk("idle_timeout", 32'(Busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_reglido"}, 32'(RegLido), 0);
    chk({tag, "_valid"}, 32'(DumpValid), 0);
    chk({tag, "_idx"}, 32'(DumpIdx), 0);
    chk({tag, "_data"}, 32'(DumpData), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < NUM_REGS; i++) begin bank[i] = '0; model[i] = '0; end
    #1 check_zero("reset");
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    check_zero("post_reset");

    // 1: free-running consumer, cycle-exact framing.
    for (int i = 0; i < NUM_REGS; i++) bank_write(i, 8'h10 + 8'(i));
    push_dump();
    DumpReady = 1'b1;
    d0 = done_cnt;
    start_dump();
    for (int c = 1; c <= 2 * NUM_REGS + 2; c++) begin
      @(negedge Clock);
      chk($sformatf("t1_valid_c%0d", c), 32'(DumpValid), 32'((c % 2 == 0) && (c <= 2 * NUM_REGS)));
      chk($sformatf("t1_done_c%0d", c), 32'(Done), 32'(c == 2 * NUM_REGS + 1));
      chk($sformatf("t1_busy_c%0d", c), 32'(Busy), 32'(c <= 2 * NUM_REGS + 1));
    end
    @(posedge Clock) #1;
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);

    // 2: backpressure on idx 3 holds the word stable.
    push_dump();
    start_dump();
    wait_word(3);
    DumpReady = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("t2_hold_valid", 32'(DumpValid), 1);
      chk("t2_hold_idx", 32'(DumpIdx), 3);
      chk("t2_hold_data", 32'(DumpData), 32'h13);
      @(posedge Clock) #1;
    end
    DumpReady = 1'b1;
    wait_idle(100);
    chk("t2_sb_empty", 32'(exp_q.size()), 0);

    // 3: Start while busy and in the DONE cycle is ignored.
    push_dump();
    d0 = done_cnt;
    start_dump();
    wait_word(2);
    start_dump();
    begin
      int k;
      for (k = 0; k < 100 && !Done; k++) @(negedge Clock);
      chk("t3_done_seen", 32'(Done), 1);
    end
    Start = 1'b1;
    @(posedge Clock) #1;
    Start = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("t3_no_restart", 32'(Busy), 0);
    end
    chk("t3_done_count", 32'(done_cnt - d0), 1);
    chk("t3_sb_empty", 32'(exp_q.size()), 0);

    // 4: asynchronous reset mid-HOLD abandons the dump.
    push_dump();
    d0 = done_cnt;
    @(posedge Clock) #1;
    start_dump();
    wait_word(5);
    DumpReady = 1'b0;
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 check_zero("t4_async");
    exp_q.delete();
    @(posedge Clock) #1;
    Reset = 1'b0;
    check_zero("t4_release");
    push_dump();
    DumpReady = 1'b1;
    start_dump();
    wait_idle(100);
    chk("t4_done_count", 32'(done_cnt - d0), 1);
    chk("t4_sb_empty", 32'(exp_q.size()), 0);

    // 5: snapshot semantics against in-flight bank writes.
    for (int i = 0; i < NUM_REGS; i++)
      exp_q.push_back('{ADDR_W'(i), (i == 6) ? 8'hBB : 8'h10 + 8'(i)});
    start_dump();
    wait_word(4);
    bank_write(4, 8'hAA);
    bank_write(6, 8'hBB);
    wait_idle(100);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);

    // 6: random backpressure over 20 dumps with fresh bank contents.
    d0 = done_cnt;
    for (int n = 0; n < 20; n++) begin
      DumpReady = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) bank_write(i, 8'($urandom));
      push_dump();
      start_dump();
      begin
        int k;
        for (k = 0; k < 300 && Busy; k++) begin
          DumpReady = 1'($urandom_range(0, 1));
          @(posedge Clock) #1;
        end
        chk("t6_idle_timeout", 32'(Busy), 0);
      end
    end
    chk("t6_done_count", 32'(done_cnt - d0), 20);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
